// File: rtl/rv32_regfile_pkg.sv
// Shared constants for the RV32IM integer register file and its write-port arbiter.
package rv32_regfile_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  // Which source produced the write currently on the register-file port
  localparam logic SRC_WB = 1'b0;
  localparam logic SRC_MD = 1'b1;

endpackage

// File: rtl/md_result_fifo.sv
// Synchronous FIFO holding {addr,data} mul/div results until they win the write port.
module md_result_fifo #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       push,
  input  logic [ADDR_W-1:0]          push_addr,
  input  logic [DATA_W-1:0]          push_data,
  input  logic                       pop,
  output logic [ADDR_W-1:0]          head_addr,
  output logic [DATA_W-1:0]          head_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [ADDR_W+DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]         wr_ptr;
  logic [PTR_W-1:0]         rd_ptr;
  logic                     do_push;
  logic                     do_pop;

  assign full    = (count == ($clog2(DEPTH)+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // A push into a full FIFO is only legal when the head leaves in the same cycle
  assign do_push = push & (~full | do_pop);

  assign {head_addr, head_data} = mem[rd_ptr];

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= {push_addr, push_data};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Serialises pipeline writeback and buffered mul/div results onto the single
// register-file write port, and tracks outstanding mul/div destinations for decode.
module reg_write_arbiter
  import rv32_regfile_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int DATA_W     = XLEN,
  parameter int ADDR_W     = REG_ADDR_W
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              WB_VALID,
  input  logic [ADDR_W-1:0] WB_ADDR,
  input  logic [DATA_W-1:0] WB_DATA,
  output logic              WB_STALL,
  input  logic              MD_VALID,
  input  logic [ADDR_W-1:0] MD_ADDR,
  input  logic [DATA_W-1:0] MD_DATA,
  output logic              MD_READY,
  input  logic              MD_ISSUE,
  input  logic [ADDR_W-1:0] MD_ISSUE_RD,
  input  logic              DEC_VALID,
  input  logic [ADDR_W-1:0] DEC_RS1,
  input  logic [ADDR_W-1:0] DEC_RS2,
  input  logic [ADDR_W-1:0] DEC_RD,
  output logic              HAZARD,
  output logic              RF_WRITE_ENABLE,
  output logic [ADDR_W-1:0] RF_WRITE_ADDRESS,
  output logic [DATA_W-1:0] RF_WRITE_DATA
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int NREGS = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic              md_push;
  logic              fifo_pop;
  logic              wb_grant;
  logic              src_md;
  logic [NREGS-1:0]  pending;
  logic [NREGS-1:0]  pending_next;

  assign MD_READY = (fifo_count != CNT_W'(FIFO_DEPTH));
  // Results for x0 are handshaken normally but never stored
  assign md_push  = MD_VALID & MD_READY & (MD_ADDR != ZERO_ADDR);

  md_result_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_md_fifo (
    .CLK       (CLK),
    .RESET     (RESET),
    .push      (md_push),
    .push_addr (MD_ADDR),
    .push_data (MD_DATA),
    .pop       (fifo_pop),
    .head_addr (head_addr),
    .head_data (head_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // A full FIFO preempts writeback so mul/div results can never starve
  always_comb begin
    fifo_pop = 1'b0;
    wb_grant = 1'b0;
    if (fifo_full && !fifo_empty) begin
      fifo_pop = 1'b1;
    end else if (WB_VALID && (WB_ADDR != ZERO_ADDR)) begin
      wb_grant = 1'b1;
    end else if (!fifo_empty) begin
      fifo_pop = 1'b1;
    end
  end

  assign WB_STALL = fifo_full & ~fifo_empty & WB_VALID;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      RF_WRITE_ENABLE  <= 1'b0;
      RF_WRITE_ADDRESS <= '0;
      RF_WRITE_DATA    <= '0;
      src_md           <= SRC_WB;
    end else begin
      RF_WRITE_ENABLE <= fifo_pop | wb_grant;
      src_md          <= fifo_pop ? SRC_MD : SRC_WB;
      if (fifo_pop) begin
        RF_WRITE_ADDRESS <= head_addr;
        RF_WRITE_DATA    <= head_data;
      end else if (wb_grant) begin
        RF_WRITE_ADDRESS <= WB_ADDR;
        RF_WRITE_DATA    <= WB_DATA;
      end
    end
  end

  // Clear while the mul/div write is on the port so the bit drops as it commits
  always_comb begin
    pending_next = pending;
    if (RF_WRITE_ENABLE && (src_md == SRC_MD)) begin
      pending_next[RF_WRITE_ADDRESS] = 1'b0;
    end
    if (MD_ISSUE) begin
      pending_next[MD_ISSUE_RD] = 1'b1;
    end
    pending_next[0] = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      pending <= '0;
    end else begin
      pending <= pending_next;
    end
  end

  assign HAZARD = DEC_VALID & (pending[DEC_RS1] | pending[DEC_RS2] | pending[DEC_RD]);

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter: hand-computed cycle expectations plus a log of committed writes.
module tb_reg_write_arbiter;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        WB_VALID;
  logic [4:0]  WB_ADDR;
  logic [31:0] WB_DATA;
  logic        WB_STALL;
  logic        MD_VALID;
  logic [4:0]  MD_ADDR;
  logic [31:0] MD_DATA;
  logic        MD_READY;
  logic        MD_ISSUE;
  logic [4:0]  MD_ISSUE_RD;
  logic        DEC_VALID;
  logic [4:0]  DEC_RS1;
  logic [4:0]  DEC_RS2;
  logic [4:0]  DEC_RD;
  logic        HAZARD;
  logic        RF_WRITE_ENABLE;
  logic [4:0]  RF_WRITE_ADDRESS;
  logic [31:0] RF_WRITE_DATA;

  int vectors = 0;
  int miscompares = 0;
  int base;
  logic [36:0] log_q [$];

  reg_write_arbiter #(.FIFO_DEPTH(2), .DATA_W(32), .ADDR_W(5)) dut (
    .CLK              (CLK),
    .RESET            (RESET),
    .WB_VALID         (WB_VALID),
    .WB_ADDR          (WB_ADDR),
    .WB_DATA          (WB_DATA),
    .WB_STALL         (WB_STALL),
    .MD_VALID         (MD_VALID),
    .MD_ADDR          (MD_ADDR),
    .MD_DATA          (MD_DATA),
    .MD_READY         (MD_READY),
    .MD_ISSUE         (MD_ISSUE),
    .MD_ISSUE_RD      (MD_ISSUE_RD),
    .DEC_VALID        (DEC_VALID),
    .DEC_RS1          (DEC_RS1),
    .DEC_RS2          (DEC_RS2),
    .DEC_RD           (DEC_RD),
    .HAZARD           (HAZARD),
    .RF_WRITE_ENABLE  (RF_WRITE_ENABLE),
    .RF_WRITE_ADDRESS (RF_WRITE_ADDRESS),
    .RF_WRITE_DATA    (RF_WRITE_DATA)
  );

  always #5 CLK = ~CLK;

  // Writes the register file actually commits (it is reset alongside the arbiter)
  always @(posedge CLK) begin
    if (RF_WRITE_ENABLE === 1'b1 && RESET === 1'b0) begin
      log_q.push_back({RF_WRITE_ADDRESS, RF_WRITE_DATA});
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] logEntry(input int i);
    if (i < log_q.size()) return 64'(log_q[i]);
    return '1;
  endfunction

  task automatic checkLog(input string tag, input int i, input logic [4:0] a, input logic [31:0] d);
    checkOutput(tag, logEntry(i), {27'd0, a, d});
  endtask

  task automatic clockCycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic setDecode(input logic v, input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
    DEC_VALID = v;
    DEC_RS1   = rs1;
    DEC_RS2   = rs2;
    DEC_RD    = rd;
  endtask

  task automatic applyStimulus(input logic wbv, input logic [4:0] wba, input logic [31:0] wbd,
                               input logic mdv, input logic [4:0] mda, input logic [31:0] mdd,
                               input logic iss, input logic [4:0] iss_rd);
    WB_VALID    = wbv;
    WB_ADDR     = wba;
    WB_DATA     = wbd;
    MD_VALID    = mdv;
    MD_ADDR     = mda;
    MD_DATA     = mdd;
    MD_ISSUE    = iss;
    MD_ISSUE_RD = iss_rd;
    #1;
  endtask

  initial begin
    RESET = 1'b1;
    setDecode(1'b0, 5'd0, 5'd0, 5'd0);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);

    $display("[TB] reset with mul/div traffic in flight");
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 32'hAAAA0004, 1'b1, 5'd4);
    clockCycle();
    clockCycle();
    RESET = 1'b0;
    setDecode(1'b1, 5'd4, 5'd4, 5'd4);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    checkOutput("rst_we", 64'(RF_WRITE_ENABLE), 64'd0);
    checkOutput("rst_addr", 64'(RF_WRITE_ADDRESS), 64'd0);
    checkOutput("rst_data", 64'(RF_WRITE_DATA), 64'd0);
    checkOutput("rst_ready", 64'(MD_READY), 64'd1);
    checkOutput("rst_hazard", 64'(HAZARD), 64'd0);
    checkOutput("rst_stall", 64'(WB_STALL), 64'd0);
    clockCycle();
    clockCycle();
    checkOutput("rst_idle_we", 64'(RF_WRITE_ENABLE), 64'd0);
    checkOutput("rst_no_writes", 64'(log_q.size()), 64'd0);
    setDecode(1'b0, 5'd0, 5'd0, 5'd0);

    $display("[TB] writeback path and x0 suppression");
    base = log_q.size();
    applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    checkOutput("wb_stall", 64'(WB_STALL), 64'd0);
    clockCycle();
    checkOutput("wb_we", 64'(RF_WRITE_ENABLE), 64'd1);
    checkOutput("wb_addr", 64'(RF_WRITE_ADDRESS), 64'd5);
    checkOutput("wb_data", 64'(RF_WRITE_DATA), 64'hDEADBEEF);
    applyStimulus(1'b1, 5'd0, 32'h00001111, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    clockCycle();
    checkOutput("wb_x0_we", 64'(RF_WRITE_ENABLE), 64'd0);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    clockCycle();
    checkOutput("wb_log_n", 64'(log_q.size() - base), 64'd1);
    checkLog("wb_log0", base, 5'd5, 32'hDEADBEEF);

    $display("[TB] collision between writeback and mul/div");
    base = log_q.size();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7);
    clockCycle();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd8);
    clockCycle();
    setDecode(1'b1, 5'd7, 5'd0, 5'd0);
    applyStimulus(1'b1, 5'd3, 32'h00000301, 1'b1, 5'd7, 32'h12345678, 1'b0, 5'd0);
    checkOutput("col_hazard_set", 64'(HAZARD), 64'd1);
    checkOutput("col_ready0", 64'(MD_READY), 64'd1);
    checkOutput("col_stall0", 64'(WB_STALL), 64'd0);
    clockCycle();
    applyStimulus(1'b1, 5'd3, 32'h00000302, 1'b1, 5'd8, 32'h00008888, 1'b0, 5'd0);
    checkOutput("col_wb_first", 64'({RF_WRITE_ENABLE, RF_WRITE_ADDRESS}), 64'h23);
    checkOutput("col_stall1", 64'(WB_STALL), 64'd0);
    clockCycle();
    applyStimulus(1'b1, 5'd3, 32'h00000303, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    checkOutput("col_stall_full", 64'(WB_STALL), 64'd1);
    checkOutput("col_ready_full", 64'(MD_READY), 64'd0);
    clockCycle();
    checkOutput("col_md_addr", 64'(RF_WRITE_ADDRESS), 64'd7);
    checkOutput("col_md_data", 64'(RF_WRITE_DATA), 64'h12345678);
    checkOutput("col_stall_once", 64'(WB_STALL), 64'd0);
    checkOutput("col_hazard_hold", 64'(HAZARD), 64'd1);
    clockCycle();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    checkOutput("col_hazard_drop", 64'(HAZARD), 64'd0);
    clockCycle();
    setDecode(1'b1, 5'd0, 5'd8, 5'd0);
    #1;
    checkOutput("col_x8_hold", 64'(HAZARD), 64'd1);
    clockCycle();
    checkOutput("col_x8_drop", 64'(HAZARD), 64'd0);
    checkOutput("col_log_n", 64'(log_q.size() - base), 64'd5);
    checkLog("col_log0", base, 5'd3, 32'h00000301);
    checkLog("col_log1", base + 1, 5'd3, 32'h00000302);
    checkLog("col_log2", base + 2, 5'd7, 32'h12345678);
    checkLog("col_log3", base + 3, 5'd3, 32'h00000303);
    checkLog("col_log4", base + 4, 5'd8, 32'h00008888);
    setDecode(1'b0, 5'd0, 5'd0, 5'd0);

    $display("[TB] fifo backpressure with writeback busy");
    base = log_q.size();
    applyStimulus(1'b1, 5'd3, 32'h00000401, 1'b1, 5'd10, 32'h000000A0, 1'b0, 5'd0);
    clockCycle();
    applyStimulus(1'b1, 5'd3, 32'h00000402, 1'b1, 5'd11, 32'h000000A1, 1'b0, 5'd0);
    checkOutput("bp_ready1", 64'(MD_READY), 64'd1);
    clockCycle();
    applyStimulus(1'b1, 5'd3, 32'h00000403, 1'b1, 5'd12, 32'h000000A2, 1'b0, 5'd0);
    checkOutput("bp_ready_full", 64'(MD_READY), 64'd0);
    checkOutput("bp_stall_a", 64'(WB_STALL), 64'd1);
    clockCycle();
    checkOutput("bp_ready_again", 64'(MD_READY), 64'd1);
    checkOutput("bp_rf_a0", 64'({RF_WRITE_ADDRESS, RF_WRITE_DATA}), {27'd0, 5'd10, 32'h000000A0});
    clockCycle();
    applyStimulus(1'b1, 5'd3, 32'h00000404, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    checkOutput("bp_stall_b", 64'(WB_STALL), 64'd1);
    checkOutput("bp_ready_full2", 64'(MD_READY), 64'd0);
    clockCycle();
    clockCycle();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    clockCycle();
    clockCycle();
    checkOutput("bp_log_n", 64'(log_q.size() - base), 64'd7);
    checkLog("bp_log0", base, 5'd3, 32'h00000401);
    checkLog("bp_log1", base + 1, 5'd3, 32'h00000402);
    checkLog("bp_log2", base + 2, 5'd10, 32'h000000A0);
    checkLog("bp_log3", base + 3, 5'd3, 32'h00000403);
    checkLog("bp_log4", base + 4, 5'd11, 32'h000000A1);
    checkLog("bp_log5", base + 5, 5'd3, 32'h00000404);
    checkLog("bp_log6", base + 6, 5'd12, 32'h000000A2);

    $display("[TB] write-after-write on x9");
    base = log_q.size();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9);
    clockCycle();
    setDecode(1'b1, 5'd1, 5'd2, 5'd9);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    checkOutput("waw_hazard", 64'(HAZARD), 64'd1);
    clockCycle();
    clockCycle();
    checkOutput("waw_hazard_wait", 64'(HAZARD), 64'd1);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h00000099, 1'b0, 5'd0);
    clockCycle();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    checkOutput("waw_hazard_pop", 64'(HAZARD), 64'd1);
    clockCycle();
    checkOutput("waw_rf_md", 64'({RF_WRITE_ENABLE, RF_WRITE_ADDRESS}), 64'h29);
    checkOutput("waw_hazard_rf", 64'(HAZARD), 64'd1);
    clockCycle();
    checkOutput("waw_hazard_drop", 64'(HAZARD), 64'd0);
    setDecode(1'b0, 5'd0, 5'd0, 5'd0);
    applyStimulus(1'b1, 5'd9, 32'h000000D9, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    clockCycle();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    clockCycle();
    checkOutput("waw_log_n", 64'(log_q.size() - base), 64'd2);
    checkLog("waw_log0", base, 5'd9, 32'h00000099);
    checkLog("waw_log_last", base + 1, 5'd9, 32'h000000D9);

    $display("[TB] reset while fifo holds results");
    applyStimulus(1'b1, 5'd3, 32'h00000501, 1'b1, 5'd13, 32'h00000C13, 1'b1, 5'd13);
    clockCycle();
    applyStimulus(1'b1, 5'd3, 32'h00000502, 1'b1, 5'd14, 32'h00000C14, 1'b1, 5'd14);
    clockCycle();
    setDecode(1'b1, 5'd13, 5'd14, 5'd0);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    checkOutput("mid_full", 64'(MD_READY), 64'd0);
    checkOutput("mid_hazard", 64'(HAZARD), 64'd1);
    base = log_q.size();
    RESET = 1'b1;
    clockCycle();
    RESET = 1'b0;
    #1;
    checkOutput("mid_we", 64'(RF_WRITE_ENABLE), 64'd0);
    checkOutput("mid_ready", 64'(MD_READY), 64'd1);
    checkOutput("mid_hazard_clr", 64'(HAZARD), 64'd0);
    clockCycle();
    checkOutput("mid_we_next", 64'(RF_WRITE_ENABLE), 64'd0);
    clockCycle();
    checkOutput("mid_no_writes", 64'(log_q.size() - base), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
